dma_write_block: RTL and testbench

DMA write-side engine, the counterpart of the DMA read block. Accepts write commands (destination address, byte count) from the descriptor processor into an internal command FIFO. Drains 256-bit beats from the DMA data FIFO (show-ahead) and issues Avalon-MM burst writes to the destination. Signals command completion back to the descriptor processor.

---
 rtl/dma_write_block.sv | 135 +++++++++++++
 tb/tb_dma_write_block.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_block.sv
// dma_write_block: DMA write engine that drains show-ahead data FIFO beats into Avalon-MM burst writes.
// Ports: command push (dma_wr_fifo_command_req_i, dma_wr_addr_i, dma_wr_bytes_to_transfer_i,
//        dma_wr_fifo_full_o, dma_wr_done_o); data FIFO (dma_data_i, dma_data_fifo_empty_i,
//        dma_data_fifo_rdreq_o); Avalon-MM master (dma_dest_addr_o, dma_dest_write_o, dma_dest_data_o,
//        dma_dest_byteenable_o, dma_dest_bcount_o, dma_dest_wait_req_i).
// Define DMA_WR_PARTIAL_BE_EN to mask the unused byte lanes on the final beat of a command.
module dma_write_block #(
  parameter int CMD_DEPTH = 32,
  parameter int MAX_BURST = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dma_wr_fifo_command_req_i,
  input  logic [15:0]  dma_wr_bytes_to_transfer_i,
  input  logic [31:0]  dma_wr_addr_i,
  output logic         dma_wr_fifo_full_o,
  output logic         dma_wr_done_o,
  input  logic [255:0] dma_data_i,
  input  logic         dma_data_fifo_empty_i,
  output logic         dma_data_fifo_rdreq_o,
  output logic [31:0]  dma_dest_addr_o,
  output logic         dma_dest_write_o,
  output logic [255:0] dma_dest_data_o,
  output logic [31:0]  dma_dest_byteenable_o,
  output logic [10:0]  dma_dest_bcount_o,
  input  logic         dma_dest_wait_req_i
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(CMD_DEPTH);
  localparam logic [11:0] MAX_B = 12'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, LD_CMD, SEND_WR, DONE} state_t;
  state_t state_q, state_d;
  logic [47:0] mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [47:0] cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [11:0] beats_rem_q, beats_rem_d, next_rem;
  logic [10:0] burst_left_q, burst_left_d, bcount_q, bcount_d;
  logic [16:0] bytes_up;
  logic push, pop, accept;
`ifdef DMA_WR_PARTIAL_BE_EN
  logic [4:0] resid_q, resid_d;
`endif
  function automatic logic [10:0] clip(input logic [11:0] n);
    return n > MAX_B ? MAX_B[10:0] : n[10:0];
  endfunction
  always_comb begin
    dma_wr_fifo_full_o = count_q == FULL_CNT;
    pop = state_q == IDLE && count_q != '0;
    // a pop in the same cycle frees the slot, so a push at full is accepted then
    push = dma_wr_fifo_command_req_i && (!dma_wr_fifo_full_o || pop);
    dma_dest_write_o = state_q == SEND_WR && !dma_data_fifo_empty_i;
    accept = dma_dest_write_o && !dma_dest_wait_req_i;
    dma_data_fifo_rdreq_o = accept;
    dma_dest_data_o = dma_data_i;
    dma_dest_addr_o = addr_q;
    dma_dest_bcount_o = bcount_q;
    dma_wr_done_o = state_q == DONE;
`ifdef DMA_WR_PARTIAL_BE_EN
    dma_dest_byteenable_o = (state_q == SEND_WR && beats_rem_q == 12'd1 && resid_q != '0) ?
                            (32'd1 << resid_q) - 32'd1 : '1;
`else
    dma_dest_byteenable_o = '1;
`endif
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    cmd_d = pop ? mem[rd_ptr_q] : cmd_q;
    bytes_up = {1'b0, cmd_q[15:0]} + 17'd31;
    next_rem = beats_rem_q - 12'd1;
    state_d = state_q;
    addr_d = addr_q;
    beats_rem_d = beats_rem_q;
    burst_left_d = burst_left_q;
    bcount_d = bcount_q;
`ifdef DMA_WR_PARTIAL_BE_EN
    resid_d = resid_q;
`endif
    case (state_q)
      IDLE: state_d = pop ? LD_CMD : IDLE;
      LD_CMD: begin
        addr_d = cmd_q[47:16] & ~32'h1F;
        beats_rem_d = bytes_up[16:5];
        burst_left_d = clip(bytes_up[16:5]);
        bcount_d = clip(bytes_up[16:5]);
`ifdef DMA_WR_PARTIAL_BE_EN
        resid_d = cmd_q[4:0];
`endif
        state_d = bytes_up[16:5] == '0 ? DONE : SEND_WR;
      end
      SEND_WR: if (accept) begin
        beats_rem_d = next_rem;
        burst_left_d = burst_left_q - 11'd1;
        if (burst_left_q == 11'd1) begin
          addr_d = addr_q + (32'(bcount_q) << 5);
          burst_left_d = clip(next_rem);
          bcount_d = next_rem == '0 ? bcount_q : clip(next_rem);
          state_d = next_rem == '0 ? DONE : SEND_WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= {dma_wr_addr_i, dma_wr_bytes_to_transfer_i};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      beats_rem_q <= '0;
      burst_left_q <= '0;
      bcount_q <= '0;
`ifdef DMA_WR_PARTIAL_BE_EN
      resid_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      beats_rem_q <= beats_rem_d;
      burst_left_q <= burst_left_d;
      bcount_q <= bcount_d;
`ifdef DMA_WR_PARTIAL_BE_EN
      resid_q <= resid_d;
`endif
    end
endmodule

// File: tb/tb_dma_write_block.sv
// tb_dma_write_block: directed bench for dma_write_block with a show-ahead data FIFO model.
module tb_dma_write_block;
  logic clk = 1'b0;
  logic reset, req, full, done, empty, rdreq, write, wait_req;
  logic [15:0] bytes;
  logic [31:0] addr_i, dest_addr, be;
  logic [255:0] data_i, dest_data;
  logic [10:0] bcount;
  always #5 clk = ~clk;
  dma_write_block dut (
    .clk(clk), .reset(reset),
    .dma_wr_fifo_command_req_i(req), .dma_wr_bytes_to_transfer_i(bytes), .dma_wr_addr_i(addr_i),
    .dma_wr_fifo_full_o(full), .dma_wr_done_o(done),
    .dma_data_i(data_i), .dma_data_fifo_empty_i(empty), .dma_data_fifo_rdreq_o(rdreq),
    .dma_dest_addr_o(dest_addr), .dma_dest_write_o(write), .dma_dest_data_o(dest_data),
    .dma_dest_byteenable_o(be), .dma_dest_bcount_o(bcount), .dma_dest_wait_req_i(wait_req)
  );
  int errors = 0, checks = 0;
  logic [255:0] dmem [0:255];
  int rd_idx, wr_cnt, cyc, beats, rdreqs, dones, last_done_cyc, viol, stall_wr, p;
  logic hold_empty;
  logic [31:0] b_addr [0:127];
  logic [10:0] b_bcnt [0:127];
  logic [31:0] b_be [0:127];
  logic [255:0] b_data [0:127];
  int b_cyc [0:127];
  logic [31:0] last_be;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive_data();
    data_i = rd_idx < wr_cnt ? dmem[rd_idx] : '0;
    empty = hold_empty || rd_idx >= wr_cnt;
  endtask
  task automatic step();
    logic popped;
    #1;
    popped = rdreq;
    if (write && !wait_req) begin
      if (beats < 128) begin
        b_addr[beats] = dest_addr;
        b_bcnt[beats] = bcount;
        b_be[beats] = be;
        b_data[beats] = dest_data;
        b_cyc[beats] = cyc;
      end
      beats++;
    end
    if (rdreq) rdreqs++;
    if (done) begin
      dones++;
      last_done_cyc = cyc;
    end
    if ((wait_req && rdreq) || (empty && (write || rdreq))) viol++;
    if (wait_req && write) stall_wr++;
    @(posedge clk);
    @(negedge clk);
    if (popped) rd_idx++;
    cyc++;
    drive_data();
  endtask
  task automatic clear_log();
    beats = 0; rdreqs = 0; dones = 0; viol = 0; stall_wr = 0; last_done_cyc = -1;
  endtask
  task automatic load_data(input int n, input int seed);
    rd_idx = 0;
    wr_cnt = n;
    for (int i = 0; i < 256; i++) dmem[i] = {8{seed + i}};
    drive_data();
  endtask
  task automatic push(input logic [31:0] a, input logic [15:0] b);
    req = 1'b1; addr_i = a; bytes = b;
    step();
    req = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && last_done_cyc < 0; i++) step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
`ifdef DMA_WR_PARTIAL_BE_EN
    last_be = 32'h0000000F;
`else
    last_be = 32'hFFFFFFFF;
`endif
    reset = 1'b1; req = 1'b0; bytes = '0; addr_i = '0; wait_req = 1'b0; hold_empty = 1'b0;
    cyc = 0; rd_idx = 0; wr_cnt = 0;
    clear_log();
    drive_data();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_write", write, 0);
    check("rst_rdreq", rdreq, 0);
    check("rst_addr", dest_addr, 0);
    check("rst_bcount", bcount, 0);
    check("rst_be", be, 32'hFFFFFFFF);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    // reset in the middle of an 8-beat burst
    load_data(16, 100);
    clear_log();
    push(32'h0000_3000, 16'd256);
    for (int i = 0; i < 20 && beats < 3; i++) step();
    check("t1_beats_before_rst", beats, 3);
    reset = 1'b1;
    #1;
    check("t1_write", write, 0);
    check("t1_rdreq", rdreq, 0);
    check("t1_addr", dest_addr, 0);
    check("t1_bcount", bcount, 0);
    check("t1_be", be, 32'hFFFFFFFF);
    check("t1_full", full, 0);
    check("t1_done", done, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t1_no_done", dones, 0);
    check("t1_beats_after_rst", beats, 3);
    // two-beat command with unaligned address
    load_data(4, 200);
    clear_log();
    p = cyc;
    push(32'h1000_0010, 16'd64);
    wait_done(20);
    check("t2_beats", beats, 2);
    check("t2_rdreqs", rdreqs, 2);
    check("t2_addr", b_addr[0], 32'h1000_0000);
    check("t2_bcount", b_bcnt[0], 2);
    check("t2_first_cyc", b_cyc[0], p + 3);
    check("t2_second_cyc", b_cyc[1], p + 4);
    check("t2_data0", b_data[0], dmem[0]);
    check("t2_data1", b_data[1], dmem[1]);
    check("t2_done_cyc", last_done_cyc, p + 5);
    check("t2_dones", dones, 1);
    // 100 bytes: four beats, last one partial when the option is enabled
    load_data(8, 300);
    clear_log();
    push(32'h0000_4000, 16'd100);
    wait_done(30);
    check("t3_beats", beats, 4);
    check("t3_bcount", b_bcnt[0], 4);
    check("t3_be0", b_be[0], 32'hFFFFFFFF);
    check("t3_be2", b_be[2], 32'hFFFFFFFF);
    check("t3_be3", b_be[3], last_be);
    check("t3_addr3", b_addr[3], 32'h0000_4000);
    // 3000 bytes splits into 64 + 30 beat bursts
    load_data(100, 400);
    clear_log();
    push(32'h0000_0000, 16'd3000);
    wait_done(300);
    check("t4_beats", beats, 94);
    check("t4_dones", dones, 1);
    check("t4_addr0", b_addr[0], 32'h0);
    check("t4_bcnt0", b_bcnt[0], 64);
    check("t4_bcnt63", b_bcnt[63], 64);
    check("t4_addr64", b_addr[64], 32'h800);
    check("t4_bcnt64", b_bcnt[64], 30);
    check("t4_addr93", b_addr[93], 32'h800);
    check("t4_data93", b_data[93], dmem[93]);
    check("t4_back_to_back", b_cyc[64], b_cyc[63] + 1);
    // waitrequest on beat 1 for 3 cycles, data FIFO empty for 2 cycles
    load_data(8, 500);
    clear_log();
    p = cyc;
    push(32'h0000_2000, 16'd256);
    for (int i = 0; i < 40 && last_done_cyc < 0; i++) begin
      wait_req = cyc >= p + 4 && cyc <= p + 6;
      hold_empty = cyc == p + 9 || cyc == p + 10;
      drive_data();
      step();
    end
    wait_req = 1'b0;
    hold_empty = 1'b0;
    drive_data();
    check("t5_beats", beats, 8);
    check("t5_rdreqs", rdreqs, 8);
    check("t5_violations", viol, 0);
    check("t5_stall_cycles", stall_wr, 3);
    check("t5_beat1_cyc", b_cyc[1], p + 7);
    check("t5_beat3_cyc", b_cyc[3], p + 11);
    check("t5_data1", b_data[1], dmem[1]);
    check("t5_data7", b_data[7], dmem[7]);
    check("t5_addr7", b_addr[7], 32'h0000_2000);
    check("t5_bcnt7", b_bcnt[7], 8);
    check("t5_done_cyc", last_done_cyc, p + 16);
    // fill the command FIFO while the data FIFO is held empty
    hold_empty = 1'b1;
    load_data(40, 600);
    clear_log();
    for (int i = 0; i < 32; i++) push(32'h0000_5000, 16'd32);
    check("t6_full_after_32", full, 0);
    push(32'h0000_5000, 16'd32);
    check("t6_full_after_33", full, 1);
    push(32'h0000_5000, 16'd32);
    check("t6_full_after_drop", full, 1);
    hold_empty = 1'b0;
    drive_data();
    for (int i = 0; i < 300; i++) step();
    check("t6_dones", dones, 33);
    check("t6_beats", beats, 33);
    check("t6_full_drained", full, 0);
    // zero-byte command
    clear_log();
    p = cyc;
    push(32'h0000_6000, 16'd0);
    wait_done(10);
    check("t6_zero_done_cyc", last_done_cyc, p + 3);
    check("t6_zero_beats", beats, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
